// File: rtl/avalon_dma_pkg.sv
// Shared types, bus widths and address helpers for the Avalon-MM block-copy DMA.
package avalon_dma_pkg;

  localparam int AVM_AW     = 32;
  localparam int AVM_DW     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } dma_state_t;

  function automatic logic [AVM_AW-1:0] align_word(input logic [AVM_AW-1:0] a);
    return a & ~AVM_AW'(WORD_BYTES - 1);
  endfunction

  // base + WORD_BYTES*idx, wrapping modulo 2^AVM_AW
  function automatic logic [AVM_AW-1:0] word_addr(input logic [AVM_AW-1:0] base,
                                                  input logic [AVM_AW-1:0] idx);
    return base + idx * AVM_AW'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/avalon_dma_copy_if.sv
// Avalon-MM master/slave signal bundle between the copy engine and a memory slave.
interface avalon_dma_copy_if;
  import avalon_dma_pkg::*;

  logic [AVM_AW-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [AVM_DW-1:0] avm_writedata;
  logic [AVM_DW-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/avalon_dma_copy_fifo.sv
// Synchronous staging FIFO (power-of-two depth) holding one read burst for the copy engine.
module dma_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/avalon_dma_copy.sv
// Avalon-MM block copy master: bursts of up to BURST_LEN reads staged in a FIFO, then written out.
module avalon_dma_copy
  import avalon_dma_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AVM_AW-1:0] src_addr,
  input  logic [AVM_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  avalon_dma_copy_if.master avm
);

  localparam int BCW = $clog2(BURST_LEN) + 1;

  dma_state_t        state_q, state_d;
  logic [AVM_AW-1:0] src_q, src_d;
  logic [AVM_AW-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [AVM_AW-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [AVM_DW-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AVM_DW-1:0] fifo_rdata;
  logic              rd_acc, wr_acc, last_rd;
  logic [LEN_W-1:0]  rd_idx_nx, wr_idx_nx;

  dma_fifo #(
    .DEPTH (BURST_LEN),
    .WIDTH (AVM_DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i (avm.avm_readdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_acc    = read_q  & ~avm.avm_waitrequest;
  assign wr_acc    = write_q & ~avm.avm_waitrequest;
  assign last_rd   = (bcnt_q == BCW'(BURST_LEN - 1)) || (rem_q == LEN_W'(1));
  assign rd_idx_nx = rd_idx_q + LEN_W'(1);
  assign wr_idx_nx = wr_idx_q + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      bcnt_q   <= '0;
      addr_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      bcnt_q   <= bcnt_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The write-data register is the head of the staging buffer: a word leaves the FIFO when it
  // is loaded there, so the final read of a 1-word burst bypasses the FIFO entirely.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    read_d    = read_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d    = align_word(src_addr);
          dst_d    = align_word(dst_addr);
          rem_d    = len_words;
          rd_idx_d = '0;
          wr_idx_d = '0;
          bcnt_d   = '0;
          if (len_words == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            read_d  = 1'b1;
            addr_d  = align_word(src_addr);
          end
        end
      end

      RD: begin
        if (rd_acc) begin
          rd_idx_d = rd_idx_nx;
          rem_d    = rem_q - LEN_W'(1);
          if (last_rd) begin
            state_d = WR;
            read_d  = 1'b0;
            write_d = 1'b1;
            bcnt_d  = '0;
            addr_d  = word_addr(dst_q, AVM_AW'(wr_idx_q));
            if (fifo_empty) begin
              wdata_d = avm.avm_readdata;
            end else begin
              wdata_d   = fifo_rdata;
              fifo_pop  = 1'b1;
              fifo_push = 1'b1;
            end
          end else begin
            bcnt_d    = bcnt_q + BCW'(1);
            fifo_push = 1'b1;
            addr_d    = word_addr(src_q, AVM_AW'(rd_idx_nx));
          end
        end
      end

      WR: begin
        if (wr_acc) begin
          wr_idx_d = wr_idx_nx;
          if (!fifo_empty) begin
            wdata_d  = fifo_rdata;
            fifo_pop = 1'b1;
            addr_d   = word_addr(dst_q, AVM_AW'(wr_idx_nx));
          end else if (rem_q != '0) begin
            state_d = RD;
            write_d = 1'b0;
            read_d  = 1'b1;
            addr_d  = word_addr(src_q, AVM_AW'(rd_idx_q));
          end else begin
            state_d = DONE;
            write_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = wdata_q;
  assign busy              = busy_q;
  assign done              = done_q;

  a_rd_has_room:   assert property (@(posedge clk) disable iff (!reset_n) (state_q == RD) |-> !fifo_full);
  a_cmd_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(read_q && write_q));

endmodule

// File: tb/tb_avalon_dma_copy.sv
// Bench for avalon_dma_copy: SRAM slave with optional stalls plus a transaction-level copy model.
module tb_avalon_dma_copy;

  localparam int BL = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_addr = '0;
  logic [31:0]   dst_addr = '0;
  logic [LW-1:0] len_words = '0;
  logic          busy;
  logic          done;

  avalon_dma_copy_if bus();

  avalon_dma_copy #(.BURST_LEN(BL), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .avm       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          last_all;
  } txn_t;

  logic [31:0] mem [4096];
  int          checks = 0;
  int          failures = 0;
  int          wait_mode = 0;  // 0: no stalls, 1: random stalls, 2: stall forever
  int          acc_rd = 0, acc_wr = 0, done_cnt = 0;
  bit          busy_seen = 0;
  bit          kind_log[$];
  logic [31:0] last_wr_addr = '0;

  assign bus.avm_readdata = mem[bus.avm_address[13:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (wait_mode)
        1:       bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
        2:       bus.avm_waitrequest = 1'b1;
        default: bus.avm_waitrequest = 1'b0;
      endcase
    end
  end

  // Reference model: on an accepted start the whole copy is expanded into the ordered list of
  // bus transactions (bursts of up to BL reads, then the same words written out).
  initial begin : model
    txn_t        q[$];
    txn_t        t;
    bit          model_busy, exp_done, exp_req, prev_stall, in_done;
    logic [31:0] p_addr, p_wdata, s, d, a;
    logic [1:0]  p_cmd;
    int          rem, idx, n;
    model_busy = 0; exp_done = 0; exp_req = 0; prev_stall = 0;
    p_addr = '0; p_wdata = '0; p_cmd = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hbade0000 | 32'(i);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        model_busy = 0; exp_done = 0; exp_req = 0; prev_stall = 0;
        continue;
      end
      in_done = exp_done;
      chk("done", done, exp_done);
      if (exp_done) model_busy = 0;
      chk("busy", busy, model_busy);
      exp_done = 0;
      chk("rd_wr_excl", bus.avm_read & bus.avm_write, 0);
      if (prev_stall) begin
        chk("stall_addr", bus.avm_address, p_addr);
        chk("stall_cmd", {bus.avm_read, bus.avm_write}, p_cmd);
        if (p_cmd[0]) chk("stall_wdata", bus.avm_writedata, p_wdata);
      end
      if (exp_req && q.size() > 0) begin
        chk("next_req", q[0].wr ? bus.avm_write : bus.avm_read, 1);
        chk("next_addr", bus.avm_address, q[0].addr);
      end
      exp_req = 0;
      if (bus.avm_read || bus.avm_write) begin
        if (q.size() == 0) begin
          chk("unexpected_req", {bus.avm_read, bus.avm_write}, 0);
        end else if (!bus.avm_waitrequest) begin
          t = q.pop_front();
          chk("acc_kind", bus.avm_write, t.wr);
          chk("acc_addr", bus.avm_address, t.addr);
          if (t.wr) begin
            chk("acc_wdata", bus.avm_writedata, t.data);
            a = bus.avm_address;
            mem[a[13:2]] = bus.avm_writedata;
            last_wr_addr = a;
            acc_wr++;
          end else begin
            acc_rd++;
          end
          kind_log.push_back(t.wr);
          if (t.last_all) exp_done = 1;
          else exp_req = 1;
        end
      end
      prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      p_addr = bus.avm_address;
      p_cmd = {bus.avm_read, bus.avm_write};
      p_wdata = bus.avm_writedata;
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (start && !model_busy && !in_done) begin
        s = src_addr & ~32'h3;
        d = dst_addr & ~32'h3;
        rem = int'(len_words);
        idx = 0;
        while (rem > 0) begin
          n = (rem < BL) ? rem : BL;
          for (int j = 0; j < n; j++)
            q.push_back('{wr: 1'b0, addr: s + 32'(4 * (idx + j)), data: '0, last_all: 1'b0});
          for (int j = 0; j < n; j++) begin
            a = s + 32'(4 * (idx + j));
            q.push_back('{wr: 1'b1, addr: d + 32'(4 * (idx + j)), data: mem[a[13:2]],
                          last_all: (rem == n) && (j == n - 1)});
          end
          idx += n;
          rem -= n;
        end
        if (len_words == '0) exp_done = 1;
        else begin
          model_busy = 1;
          exp_req = 1;
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int l);
    @(posedge clk);
    #1;
    src_addr = s;
    dst_addr = d;
    len_words = LW'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max_cycles);
    int c = 0;
    while (done_cnt == d0 && c < max_cycles) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("done_within_budget", done_cnt - d0, 1);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l);
    logic [31:0] exp_w[$];
    logic [31:0] a;
    int d0;
    for (int i = 0; i < l; i++) begin
      a = (s & ~32'h3) + 32'(4 * i);
      exp_w.push_back(mem[a[13:2]]);
    end
    d0 = done_cnt;
    pulse_start(s, d, l);
    wait_done(d0, 3000);
    for (int i = 0; i < l; i++) begin
      a = (d & ~32'h3) + 32'(4 * i);
      chk("dst_word", mem[a[13:2]], exp_w[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          d0, r0, w0;
    logic [31:0] a;
    logic [31:0] other[3];
    logic [31:0] orig[9];
    bit          exp_k[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", bus.avm_read, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_address", bus.avm_address, 0);
    chk("rst_writedata", bus.avm_writedata, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // 8-word copy 0x000 -> 0x1000 with literal expectations
    r0 = acc_rd; w0 = acc_wr; d0 = done_cnt;
    pulse_start(32'h0, 32'h1000, 8);
    chk("t1_busy_n1", busy, 1);
    chk("t1_read_n1", bus.avm_read, 1);
    chk("t1_addr_n1", bus.avm_address, 32'h0);
    wait_done(d0, 500);
    repeat (4) @(negedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk("t1_mem", mem[12'h400 + 12'(i)], 32'hbade0000 + 32'(i));
    chk("t1_reads", acc_rd - r0, 8);
    chk("t1_writes", acc_wr - w0, 8);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // zero length
    r0 = acc_rd; w0 = acc_wr; d0 = done_cnt; busy_seen = 0;
    pulse_start(32'h40, 32'h2040, 0);
    chk("t2_done_n1", done, 1);
    chk("t2_busy_n1", busy, 0);
    wait_done(d0, 20);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_busy_never", busy_seen, 0);
    chk("t2_no_reads", acc_rd - r0, 0);
    chk("t2_no_writes", acc_wr - w0, 0);

    // 5 words: 4R 4W 1R 1W
    kind_log.delete();
    run_copy(32'h100, 32'h2100, 5);
    chk("t3_txn_count", kind_log.size(), 10);
    for (int i = 0; i < 10 && i < kind_log.size(); i++) chk("t3_phase", kind_log[i], exp_k[i]);
    chk("t3_last_wr_addr", last_wr_addr, 32'h2110);

    // 10-cycle stalls on one read and one write
    r0 = acc_rd; w0 = acc_wr; d0 = done_cnt;
    wait_mode = 2;
    pulse_start(32'h200, 32'h2200, 1);
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    chk("t4_rd_stalled", bus.avm_read, 1);
    chk("t4_no_rd_yet", acc_rd - r0, 0);
    wait_mode = 0;
    @(negedge clk);
    #1;
    wait_mode = 2;
    chk("t4_one_rd", acc_rd - r0, 1);
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    chk("t4_wr_stalled", bus.avm_write, 1);
    chk("t4_no_wr_yet", acc_wr - w0, 0);
    wait_mode = 0;
    wait_done(d0, 50);
    chk("t4_one_wr", acc_wr - w0, 1);
    chk("t4_data", mem[12'h880], 32'hbade0080);

    // start mid-transfer is ignored
    wait_mode = 1;
    for (int i = 0; i < 9; i++) orig[i] = mem[12'h0C0 + 12'(i)];
    for (int i = 0; i < 3; i++) other[i] = mem[12'hA00 + 12'(i)];
    d0 = done_cnt;
    pulse_start(32'h300, 32'h2300, 9);
    repeat (6) @(negedge clk);
    chk("t5_busy_mid", busy, 1);
    pulse_start(32'h500, 32'h2800, 3);
    wait_done(d0, 2000);
    repeat (6) @(negedge clk);
    #1;
    chk("t5_single_done", done_cnt - d0, 1);
    for (int i = 0; i < 9; i++) chk("t5_dst", mem[12'h8C0 + 12'(i)], orig[i]);
    for (int i = 0; i < 3; i++) chk("t5_untouched", mem[12'hA00 + 12'(i)], other[i]);
    wait_mode = 0;

    // reset during the write phase
    d0 = done_cnt;
    pulse_start(32'h600, 32'h2600, 8);
    for (int c = 0; c < 200 && !bus.avm_write; c++) @(negedge clk);
    chk("t6_reached_wr", bus.avm_write, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_read", bus.avm_read, 0);
    chk("t6_write", bus.avm_write, 0);
    chk("t6_address", bus.avm_address, 0);
    chk("t6_writedata", bus.avm_writedata, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_done", done_cnt - d0, 0);
    run_copy(32'h600, 32'h2600, 8);

    // address wrap and unaligned inputs
    run_copy(32'hFFFF_FFFA, 32'h3001, 4);
    chk("t7_wrap_last", last_wr_addr, 32'h300C);

    // randomized copies with random stalls
    wait_mode = 1;
    for (int k = 0; k < 12; k++) begin
      run_copy(32'($urandom_range(0, 32'h1F00)), 32'h2000 + 32'($urandom_range(0, 32'h1F00)),
               int'($urandom_range(0, 20)));
    end
    wait_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
